// File: rtl/ram_port_arbiter.sv
// Two-requester front end for the single-port data RAM: arbitrates m0/m1, latches one
// request, screens it for alignment/range/encoding errors, then runs one RAM access.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_we,
  input  logic [2:0]  m0_access,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_resp_valid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_we,
  input  logic [2:0]  m1_access,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_resp_valid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        ram_load,
  output logic        ram_store,
  output logic [2:0]  ram_access,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef struct packed {
    logic        we;
    logic [2:0]  access;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t            state;
  req_t              req_q, req_in;
  logic              owner, last_grant, err_q, gnt1, hs, err_in;
  logic [1:0]        resp_v, resp_err;
  logic [1:0][31:0]  rdata_q;

  function automatic logic chk_err(input req_t r);
    logic bad;
    bad = 1'b0;
    case (r.access)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = r.addr[0];
      3'b010:         bad = |r.addr[1:0];
      default:        bad = 1'b1;
    endcase
    // Stores have no sign/zero-extended forms.
    if (r.we && r.access[2]) bad = 1'b1;
    if ((r.addr >> ADDR_WIDTH) != 32'd0) bad = 1'b1;
    return bad;
  endfunction

  // last_grant: 0 = m0, 1 = m1. m1 wins a tie only when m0 went last.
  assign gnt1     = m1_valid && (!m0_valid || (!FIXED_PRIO && !last_grant));
  assign m0_ready = (state == IDLE) && m0_valid && !gnt1;
  assign m1_ready = (state == IDLE) && gnt1;
  assign hs       = (state == IDLE) && (m0_valid || m1_valid);
  assign req_in   = gnt1 ? '{m1_we, m1_access, m1_addr, m1_wdata}
                         : '{m0_we, m0_access, m0_addr, m0_wdata};
  assign err_in   = chk_err(req_in);

  assign ram_access    = req_q.access;
  assign ram_addr      = req_q.addr;
  assign ram_data_in   = req_q.wdata;
  assign m0_resp_valid = resp_v[0];
  assign m1_resp_valid = resp_v[1];
  assign m0_err        = resp_err[0];
  assign m1_err        = resp_err[1];
  assign m0_rdata      = rdata_q[0];
  assign m1_rdata      = rdata_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_q      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
      ram_load   <= 1'b0;
      ram_store  <= 1'b0;
      resp_v     <= '0;
      resp_err   <= '0;
      rdata_q    <= '0;
    end else begin
      resp_v <= '0;
      case (state)
        IDLE: if (hs) begin
          owner      <= gnt1;
          last_grant <= gnt1;
          req_q      <= req_in;
          err_q      <= err_in;
          ram_load   <= !req_in.we && !err_in;
          ram_store  <= req_in.we && !err_in;
          state      <= ACCESS;
        end
        ACCESS: begin
          ram_load        <= 1'b0;
          ram_store       <= 1'b0;
          rdata_q[owner]  <= ram_load ? ram_data_out : 32'd0;
          resp_err[owner] <= err_q;
          resp_v[owner]   <= 1'b1;
          state           <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural byte RAM behind the port and a
// second FIXED_PRIO instance used only for the grant-order check.
module tb_ram_port_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic m0_valid = 0, m0_we = 0, m1_valid = 0, m1_we = 0;
  logic [2:0] m0_access = 0, m1_access = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_ready, m1_ready, m0_resp_valid, m1_resp_valid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic ram_load, ram_store;
  logic [2:0] ram_access;
  logic [31:0] ram_addr, ram_data_in, ram_data_out;

  logic fp_valid = 0;
  logic fp_m0_ready, fp_m1_ready, fp_rv0, fp_rv1, fp_e0, fp_e1, fp_ld, fp_st;
  logic [31:0] fp_rd0, fp_rd1, fp_addr, fp_din;
  logic [2:0] fp_acc;

  int checks = 0, failures = 0;

  ram_port_arbiter #(.ADDR_WIDTH(11), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_access(m0_access),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_resp_valid(m0_resp_valid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_access(m1_access),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_resp_valid(m1_resp_valid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_load(ram_load), .ram_store(ram_store), .ram_access(ram_access),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out));

  ram_port_arbiter #(.ADDR_WIDTH(11), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst(rst),
    .m0_valid(fp_valid), .m0_ready(fp_m0_ready), .m0_we(1'b0), .m0_access(3'b010),
    .m0_addr(32'h10), .m0_wdata(32'h0), .m0_resp_valid(fp_rv0),
    .m0_rdata(fp_rd0), .m0_err(fp_e0),
    .m1_valid(fp_valid), .m1_ready(fp_m1_ready), .m1_we(1'b0), .m1_access(3'b010),
    .m1_addr(32'h40), .m1_wdata(32'h0), .m1_resp_valid(fp_rv1),
    .m1_rdata(fp_rd1), .m1_err(fp_e1),
    .ram_load(fp_ld), .ram_store(fp_st), .ram_access(fp_acc),
    .ram_addr(fp_addr), .ram_data_in(fp_din), .ram_data_out(32'h0));

  // Little-endian byte RAM: combinational read, posedge write.
  logic [7:0] mem [0:2047] = '{default: 8'h00};
  logic [10:0] a;
  logic [15:0] h;
  assign a = ram_addr[10:0];
  always_comb begin
    h = {mem[{a[10:1], 1'b1}], mem[{a[10:1], 1'b0}]};
    case (ram_access)
      3'b000:  ram_data_out = {{24{mem[a][7]}}, mem[a]};
      3'b100:  ram_data_out = {24'd0, mem[a]};
      3'b001:  ram_data_out = {{16{h[15]}}, h};
      3'b101:  ram_data_out = {16'd0, h};
      3'b010:  ram_data_out = {mem[{a[10:2], 2'd3}], mem[{a[10:2], 2'd2}],
                               mem[{a[10:2], 2'd1}], mem[{a[10:2], 2'd0}]};
      default: ram_data_out = 32'd0;
    endcase
  end
  always @(posedge clk) if (ram_store) begin
    case (ram_access)
      3'b000: mem[a] <= ram_data_in[7:0];
      3'b001: begin mem[a] <= ram_data_in[7:0]; mem[a + 11'd1] <= ram_data_in[15:8]; end
      3'b010: begin
        mem[a] <= ram_data_in[7:0];          mem[a + 11'd1] <= ram_data_in[15:8];
        mem[a + 11'd2] <= ram_data_in[23:16]; mem[a + 11'd3] <= ram_data_in[31:24];
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request from requester m; returns response data/err, accept-to-response cycles,
  // whether the RAM strobes fired, and whether the other requester saw a response.
  task automatic xfer(input bit m, input bit we, input logic [2:0] acc,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat,
                      output bit saw_ram, output bit saw_other);
    int n;
    rd = '0; er = 1'b0; lat = 0; saw_ram = 0; saw_other = 0;
    @(negedge clk);
    if (!m) begin m0_valid = 1; m0_we = we; m0_access = acc; m0_addr = addr; m0_wdata = wd; end
    else    begin m1_valid = 1; m1_we = we; m1_access = acc; m1_addr = addr; m1_wdata = wd; end
    n = 0;
    #1;
    while (!(m ? m1_ready : m0_ready) && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) begin chk("ready_timeout", 32'd1, 32'd0); m0_valid = 0; m1_valid = 0; return; end
    @(posedge clk);
    #1;
    m0_valid = 0; m1_valid = 0;
    lat = 1;
    forever begin
      saw_ram   = saw_ram | ram_load | ram_store;
      saw_other = saw_other | (m ? m0_resp_valid : m1_resp_valid);
      if ((m ? m1_resp_valid : m0_resp_valid) || lat >= 10) break;
      @(posedge clk); #1; lat++;
    end
    if (lat >= 10) chk("resp_timeout", 32'd1, 32'd0);
    rd = m ? m1_rdata : m0_rdata;
    er = m ? m1_err : m0_err;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  logic [31:0] rd;
  logic er;
  int lat;
  bit sr, so;

  initial begin
    #2;
    chk("rst_ram_load", ram_load, 0);
    chk("rst_ram_store", ram_store, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_resp_valid", {m0_resp_valid, m1_resp_valid}, 0);
    repeat (2) @(negedge clk);
    rst = 1;

    xfer(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, sr, so);
    chk("sw_err", er, 0);
    chk("sw_lat", lat, 2);
    xfer(0, 0, 3'b010, 32'h10, 0, rd, er, lat, sr, so);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err", er, 0);
    chk("lw_lat", lat, 2);

    xfer(0, 1, 3'b000, 32'h13, 32'h000000A5, rd, er, lat, sr, so);
    chk("sb_rdata_zero", rd, 0);
    xfer(0, 0, 3'b000, 32'h13, 0, rd, er, lat, sr, so);
    chk("lb_data", rd, 32'hFFFFFFA5);
    xfer(0, 0, 3'b100, 32'h13, 0, rd, er, lat, sr, so);
    chk("lbu_data", rd, 32'h000000A5);
    xfer(0, 0, 3'b010, 32'h10, 0, rd, er, lat, sr, so);
    chk("lw_after_sb", rd, 32'hA5ADBEEF);

    // Error screening: misaligned, out of range, bad encoding.
    xfer(0, 0, 3'b010, 32'h12, 0, rd, er, lat, sr, so);
    chk("lw_mis_err", er, 1); chk("lw_mis_rd", rd, 0); chk("lw_mis_ram", sr, 0);
    xfer(0, 0, 3'b001, 32'h11, 0, rd, er, lat, sr, so);
    chk("lh_mis_err", er, 1); chk("lh_mis_rd", rd, 0); chk("lh_mis_ram", sr, 0);
    xfer(0, 1, 3'b010, 32'h800, 32'h11111111, rd, er, lat, sr, so);
    chk("sw_oor_err", er, 1); chk("sw_oor_ram", sr, 0);
    xfer(0, 0, 3'b011, 32'h10, 0, rd, er, lat, sr, so);
    chk("acc011_err", er, 1); chk("acc011_rd", rd, 0); chk("acc011_ram", sr, 0);
    xfer(0, 1, 3'b100, 32'h14, 32'h77, rd, er, lat, sr, so);
    chk("sbu_err", er, 1); chk("sbu_ram", sr, 0);
    xfer(0, 0, 3'b010, 32'h0, 0, rd, er, lat, sr, so);
    chk("mem0_unchanged", rd, 0);
    xfer(0, 0, 3'b010, 32'h10, 0, rd, er, lat, sr, so);
    chk("mem10_unchanged", rd, 32'hA5ADBEEF);

    // m1 path; m0 must see no response.
    xfer(1, 1, 3'b001, 32'h22, 32'h1234, rd, er, lat, sr, so);
    chk("m1_sh_err", er, 0); chk("m1_sh_other", so, 0); chk("m1_sh_lat", lat, 2);
    xfer(1, 0, 3'b101, 32'h22, 0, rd, er, lat, sr, so);
    chk("m1_lhu_data", rd, 32'h00001234); chk("m1_lhu_other", so, 0);
    chk("m0_rdata_held", m0_rdata, 32'hA5ADBEEF);

    // Arbitration with both held valid, starting from reset so m0 takes the first tie.
    do_reset();
    begin
      logic [3:0] seq;
      int ng, fp0, fp1;
      bit both;
      seq = '0; ng = 0; fp0 = 0; fp1 = 0; both = 0;
      @(negedge clk);
      m0_valid = 1; m0_we = 0; m0_access = 3'b010; m0_addr = 32'h10;
      m1_valid = 1; m1_we = 0; m1_access = 3'b010; m1_addr = 32'h40;
      fp_valid = 1;
      for (int i = 0; i < 12; i++) begin
        #1;
        if (m0_ready) begin seq = {seq[2:0], 1'b0}; ng++; end
        if (m1_ready) begin seq = {seq[2:0], 1'b1}; ng++; end
        both = both | (m0_ready & m1_ready);
        if (fp_m0_ready) fp0++;
        if (fp_m1_ready) fp1++;
        @(negedge clk);
      end
      m0_valid = 0; m1_valid = 0; fp_valid = 0;
      chk("rr_count", ng, 4);
      chk("rr_order", {28'd0, seq}, 32'b0101);
      chk("rr_never_both", both, 0);
      chk("fp_m0_grants", fp0, 4);
      chk("fp_m1_grants", fp1, 0);
      repeat (4) @(negedge clk);
    end

    // Reset during the ACCESS cycle of a store must kill the write and the response.
    begin
      bit saw_rv;
      int n;
      saw_rv = 0; n = 0;
      @(negedge clk);
      m0_valid = 1; m0_we = 1; m0_access = 3'b010; m0_addr = 32'h30; m0_wdata = 32'h55;
      #1;
      while (!m0_ready && n < 20) begin @(negedge clk); #1; n++; end
      chk("rst_acc_ready", m0_ready, 1);
      @(posedge clk); #1;
      m0_valid = 0;
      chk("rst_acc_store_on", ram_store, 1);
      rst = 0;
      #1;
      chk("rst_acc_store_off", ram_store, 0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 1) rst = 1;
        saw_rv = saw_rv | m0_resp_valid | m1_resp_valid;
      end
      chk("rst_acc_no_resp", saw_rv, 0);
    end
    xfer(0, 0, 3'b010, 32'h30, 0, rd, er, lat, sr, so);
    chk("rst_acc_mem_old", rd, 0);
    chk("rst_acc_lw_err", er, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
